// File: rtl/rvi_bj_redirect_ctrl_pkg.sv
// Shared RVI branch/jump types: redirect FSM state and the execute-stage branch bundle.
// Address fields are sized for the widest datapath; narrower builds zero-extend into them.
package rvi_bj_redirect_ctrl_pkg;

    localparam int unsigned BJ_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        REDIR,
        DRAIN
    } BjRdrState_e;

    typedef struct packed {
        logic [1:0]          bj_en;
        logic [BJ_MAX_W-1:0] tgt_addr;
        logic [BJ_MAX_W-1:0] nxt_pc;
        logic                pred_taken;
        logic [BJ_MAX_W-1:0] pred_tgt;
    } BjExInfo_s;

endpackage

// File: rtl/rvi_bj_misp_det.sv
// Combinational mispredict detection and redirect-PC selection for one resolved branch/jump.
module rvi_bj_misp_det
    import rvi_bj_redirect_ctrl_pkg::*;
#(
    parameter int unsigned CPU_WIDTH = 32
) (
    input  BjExInfo_s            ex_info,
    output logic                 misp,
    output logic [CPU_WIDTH-1:0] rdr_pc
);

    logic taken;
    logic tgt_diff;

    always_comb begin
        taken    = |ex_info.bj_en;
        // Upper bits are zero-extended, so a full-width compare equals a CPU_WIDTH compare.
        tgt_diff = (ex_info.tgt_addr != ex_info.pred_tgt);
        misp     = (taken != ex_info.pred_taken) | (taken & ex_info.pred_taken & tgt_diff);
        rdr_pc   = taken ? ex_info.tgt_addr[CPU_WIDTH-1:0] : ex_info.nxt_pc[CPU_WIDTH-1:0];
    end

    if (CPU_WIDTH < BJ_MAX_W) begin : g_pad
        logic unused_hi;
        assign unused_hi = ^{ex_info.tgt_addr[BJ_MAX_W-1:CPU_WIDTH],
                             ex_info.nxt_pc[BJ_MAX_W-1:CPU_WIDTH]};
    end

endmodule

// File: rtl/rvi_bj_redirect_ctrl.sv
// Branch/jump redirect sequencer: IDLE -> REDIR (held redirect) -> DRAIN (fixed window) -> IDLE.
// Optional mispredict counter port enabled by ZION_RVI_BJ_STAT_EN.
module rvi_bj_redirect_ctrl
    import rvi_bj_redirect_ctrl_pkg::*;
#(
    parameter int unsigned RV64      = 0,
    parameter int unsigned CPU_WIDTH = 32 * (RV64 + 1),
    parameter int unsigned FLUSH_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 exVld,
    output logic                 exRdy,
    input  logic [1:0]           exBjEn,
    input  logic [CPU_WIDTH-1:0] exTgtAddr,
    input  logic [CPU_WIDTH-1:0] exNxtPc,
    input  logic                 exPredTaken,
    input  logic [CPU_WIDTH-1:0] exPredTgt,
    output logic                 rdrVld,
    input  logic                 rdrRdy,
    output logic [CPU_WIDTH-1:0] rdrPc,
    output logic                 flush
`ifdef ZION_RVI_BJ_STAT_EN
   ,output logic [31:0]          mispCnt
`endif
);

    localparam logic [3:0] DRAIN_LOAD = (FLUSH_CYC == 0) ? 4'd0 : 4'(FLUSH_CYC - 1);

    BjRdrState_e          state;
    BjExInfo_s            ex_info;
    logic                 misp;
    logic [CPU_WIDTH-1:0] misp_pc;
    logic [CPU_WIDTH-1:0] rdr_pc_q;
    logic                 rdr_vld_q;
    logic                 flush_q;
    logic [3:0]           drain_cnt;
    logic                 xfer_misp;

    always_comb begin
        ex_info                        = '0;
        ex_info.bj_en                  = exBjEn;
        ex_info.tgt_addr[CPU_WIDTH-1:0] = exTgtAddr;
        ex_info.nxt_pc[CPU_WIDTH-1:0]   = exNxtPc;
        ex_info.pred_taken             = exPredTaken;
        ex_info.pred_tgt[CPU_WIDTH-1:0] = exPredTgt;
    end

    rvi_bj_misp_det #(
        .CPU_WIDTH(CPU_WIDTH)
    ) u_misp_det (
        .ex_info(ex_info),
        .misp   (misp),
        .rdr_pc (misp_pc)
    );

    assign exRdy     = (state == IDLE);
    assign xfer_misp = exVld & exRdy & misp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rdr_vld_q <= 1'b0;
            rdr_pc_q  <= '0;
            flush_q   <= 1'b0;
            drain_cnt <= '0;
        end else begin
            flush_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer_misp) begin
                        rdr_pc_q  <= misp_pc;
                        rdr_vld_q <= 1'b1;
                        flush_q   <= 1'b1;
                        state     <= REDIR;
                    end
                end
                REDIR: begin
                    if (rdrRdy) begin
                        rdr_vld_q <= 1'b0;
                        if (FLUSH_CYC == 0) begin
                            state <= IDLE;
                        end else begin
                            state     <= DRAIN;
                            drain_cnt <= DRAIN_LOAD;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rdrVld = rdr_vld_q;
    assign rdrPc  = rdr_pc_q;
    assign flush  = flush_q;

`ifdef ZION_RVI_BJ_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispCnt <= '0;
        end else if (xfer_misp && (mispCnt != '1)) begin
            mispCnt <= mispCnt + 32'd1;
        end
    end
`endif

endmodule
